// File: rtl/scale_factor_glide.sv
// Pitch scale-factor slew limiter: glides the applied 2Q21 scale toward each new target per sample tick.
// Optional build macro SCALE_CLAMP_EN limits captured factors to [MIN_SCALE, MAX_SCALE].
module scale_factor_glide #(
    parameter int                     SCALE_WIDTH   = 24,
    parameter int                     FRAC_BITS     = 21,
    parameter int                     GLIDE_SHIFT   = 3,
    parameter int                     TIMEOUT_TICKS = 4800,
    parameter logic [SCALE_WIDTH-1:0] MIN_SCALE     = 24'h100000,
    parameter logic [SCALE_WIDTH-1:0] MAX_SCALE     = 24'h400000
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    input  logic [SCALE_WIDTH-1:0] i_factor,
    input  logic                   i_factor_valid,
    input  logic                   i_sample_tick,
    output logic [SCALE_WIDTH-1:0] o_scale,
    output logic                   o_scale_update,
    output logic                   o_tracking
);
    localparam int                     CNT_W  = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [SCALE_WIDTH-1:0] UNITY  = SCALE_WIDTH'(1) << FRAC_BITS;
    localparam logic [CNT_W-1:0]       TO_CNT = CNT_W'(TIMEOUT_TICKS);

    typedef enum logic [1:0] {S_EMPTY, S_LOCKED, S_GLIDE, S_RELEASE} state_t;

    state_t                  r_state;
    logic [SCALE_WIDTH-1:0]  r_scale;
    logic [SCALE_WIDTH-1:0]  r_target;
    logic [CNT_W-1:0]        r_count;
    logic                    r_update;
    logic                    r_tracking;

    logic [SCALE_WIDTH-1:0]  w_factor;
    logic signed [SCALE_WIDTH:0] w_diff;
    logic signed [SCALE_WIDTH:0] w_shift;
    logic signed [SCALE_WIDTH:0] w_step;
    logic [SCALE_WIDTH:0]    w_sum;
    logic [SCALE_WIDTH-1:0]  w_scale_step;
    logic [CNT_W-1:0]        w_cnt_inc;

`ifdef SCALE_CLAMP_EN
    assign w_factor = (i_factor < MIN_SCALE) ? MIN_SCALE :
                      (i_factor > MAX_SCALE) ? MAX_SCALE : i_factor;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{MIN_SCALE, MAX_SCALE};
    assign w_factor     = i_factor;
`endif

    // A shifted step of zero is forced to +/-1 so the glide always lands exactly.
    assign w_diff  = $signed({1'b0, r_target}) - $signed({1'b0, r_scale});
    assign w_shift = w_diff >>> GLIDE_SHIFT;
    always_comb begin
        w_step = w_shift;
        if (w_shift == '0 && w_diff != '0)
            w_step = w_diff[SCALE_WIDTH] ? '1 : (SCALE_WIDTH+1)'(1);
    end
    assign w_sum        = {1'b0, r_scale} + w_step;
    assign w_scale_step = (i_sample_tick && r_scale != r_target) ? w_sum[SCALE_WIDTH-1:0] : r_scale;
    assign w_cnt_inc    = (r_count == TO_CNT) ? r_count : r_count + 1'b1;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= S_EMPTY;
            r_scale    <= UNITY;
            r_target   <= UNITY;
            r_count    <= '0;
            r_update   <= 1'b0;
            r_tracking <= 1'b0;
        end else begin
            r_update <= 1'b0;
            case (r_state)
                S_EMPTY: begin
                    r_count <= '0;
                    if (i_factor_valid) begin
                        r_scale    <= w_factor;
                        r_target   <= w_factor;
                        r_update   <= (w_factor != r_scale);
                        r_state    <= S_LOCKED;
                        r_tracking <= 1'b1;
                    end
                end
                S_LOCKED, S_GLIDE: begin
                    r_scale  <= w_scale_step;
                    r_update <= (w_scale_step != r_scale);
                    if (i_factor_valid) begin
                        r_target <= w_factor;
                        r_count  <= '0;
                        if (r_state == S_GLIDE || w_factor != r_scale)
                            r_state <= S_GLIDE;
                    end else if (i_sample_tick) begin
                        r_count <= w_cnt_inc;
                        if (w_cnt_inc == TO_CNT) begin
                            r_state    <= S_RELEASE;
                            r_target   <= UNITY;
                            r_count    <= '0;
                            r_tracking <= 1'b0;
                        end else if (w_scale_step == r_target) begin
                            r_state <= S_LOCKED;
                        end
                    end
                end
                S_RELEASE: begin
                    r_count  <= '0;
                    r_scale  <= w_scale_step;
                    r_update <= (w_scale_step != r_scale);
                    if (i_factor_valid) begin
                        r_target   <= w_factor;
                        r_state    <= S_GLIDE;
                        r_tracking <= 1'b1;
                    end else if (w_scale_step == UNITY) begin
                        r_state <= S_EMPTY;
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    assign o_scale        = r_scale;
    assign o_scale_update = r_update;
    assign o_tracking     = r_tracking;
endmodule
